// File: rtl/mmio_decoder_v2.sv
// mmio_decoder_v2 -- MMIO address decoder and bus front-end.
//
// Splits core data accesses into cacheable traffic (cache_access) and MMIO
// traffic routed to one of NUM_SLOTS device slots.
//
// Slot 0 holds the decoder's own control registers:
//   - staged base/bound
//   - active base/bound readback
//   - commit
//   - status: {err_count, cfg_error}
//
// Slots 1..NUM_SLOTS-1 are external devices, accessed through a registered
// select/ready handshake.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   data_address/store    core byte address / write data
//   data_read/enable      1 = load, 0 = store / request (held until data_ready)
//   data_fetch            read response data
//   data_ready, bus_error one-cycle completion pulse / error flag with it
//   cache_access(_ff)     access falls outside the active MMIO window (+reg)
//   slot_sel              one-hot device select (bit 0 never set)
//   mmio_addr/wdata/read  latched slot offset, store data, direction
//   slot_ready/rdata      per-slot completion and read data (32 bits/slot)
//
// Optional build macro MMIO_DECODER_TIMEOUT_EN: a device that stays silent
// for TIMEOUT_CYCLES WAIT cycles completes with bus_error and 32'hDEAD_BEEF.

// Per-slot lane: gates one device's ready/rdata with its select bit, so the
// top level merges the lanes with a plain OR.
module mmio_decoder_v2_slot (
  input  logic        sel,
  input  logic        ready,
  input  logic [31:0] rdata,
  output logic        hit,
  output logic [31:0] rdata_q
);
  assign hit     = sel & ready;
  assign rdata_q = sel ? rdata : 32'h0;
endmodule

module mmio_decoder_v2 #(
  parameter int          NUM_SLOTS      = 8,
  parameter int          SLOT_BYTES     = 1024,
  parameter logic [31:0] DEFAULT_BASE   = 32'h0020_0000,
  parameter logic [31:0] DEFAULT_BOUND  = 32'h0040_0000,
  parameter int          TIMEOUT_CYCLES = 15
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [31:0]             data_address,
  input  logic [31:0]             data_store,
  input  logic                    data_read,
  input  logic                    data_enable,
  output logic [31:0]             data_fetch,
  output logic                    data_ready,
  output logic                    bus_error,
  output logic                    cache_access,
  output logic                    cache_access_ff,
  output logic [NUM_SLOTS-1:0]    slot_sel,
  output logic [31:0]             mmio_addr,
  output logic [31:0]             mmio_wdata,
  output logic                    mmio_read,
  input  logic [NUM_SLOTS-1:0]    slot_ready,
  input  logic [32*NUM_SLOTS-1:0] slot_rdata
);

  localparam int               SB_W     = $clog2(SLOT_BYTES);
  localparam int               IDX_W    = 32 - SB_W;
  localparam logic [63:0]      MIN_SPAN = 64'(NUM_SLOTS) * 64'(SLOT_BYTES);
  localparam logic [IDX_W-1:0] NS_IDX   = IDX_W'(NUM_SLOTS);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [31:0] R_STG_BASE  = 32'h00;
  localparam logic [31:0] R_STG_BOUND = 32'h04;
  localparam logic [31:0] R_ACT_BASE  = 32'h08;
  localparam logic [31:0] R_ACT_BOUND = 32'h0C;
  localparam logic [31:0] R_COMMIT    = 32'h10;
  localparam logic [31:0] R_STATUS    = 32'h14;

  logic [1:0]  state;
  logic [31:0] act_base, act_bound, stg_base, stg_bound;
  logic        cfg_error;
  logic [15:0] err_count;

  // ---------------- address decode (active pair only) ----------------
  logic             in_range, is_dev, idle_accept;
  logic [31:0]      offset;
  logic [IDX_W-1:0] slot_idx;

  assign in_range     = (data_address >= act_base) && (data_address < act_bound);
  assign offset       = data_address - act_base;
  assign slot_idx     = offset[31:SB_W];
  assign is_dev       = in_range && (slot_idx != '0) && (slot_idx < NS_IDX);
  assign cache_access = data_enable && !in_range;
  assign idle_accept  = (state == S_IDLE) && data_enable && in_range;

  // Full 32-bit offset compare: a match also implies slot 0.
  logic        ctrl_hit;
  logic [31:0] ctrl_rdata;

  always_comb begin
    ctrl_hit   = 1'b1;
    ctrl_rdata = 32'h0;
    case (offset)
      R_STG_BASE:  ctrl_rdata = stg_base;
      R_STG_BOUND: ctrl_rdata = stg_bound;
      R_ACT_BASE:  ctrl_rdata = act_base;
      R_ACT_BOUND: ctrl_rdata = act_bound;
      R_COMMIT:    ctrl_rdata = 32'h0;
      R_STATUS:    ctrl_rdata = {err_count, 15'h0, cfg_error};
      default:     ctrl_hit   = 1'b0;
    endcase
  end

  logic ctrl_wr, commit_ok;
  assign ctrl_wr   = idle_accept && !is_dev && ctrl_hit && !data_read;
  // Window must be non-empty and wide enough to hold every slot.
  assign commit_ok = (stg_bound > stg_base) &&
                     ({32'h0, stg_bound - stg_base} >= MIN_SPAN);

  // ---------------- device lanes ----------------
  logic [NUM_SLOTS-1:0]       lane_hit;
  logic [NUM_SLOTS-1:0][31:0] lane_rdata;
  logic                       dev_ready;
  logic [31:0]                dev_rdata;

  generate
    for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
      mmio_decoder_v2_slot u_slot (
        .sel     (slot_sel[g]),
        .ready   (slot_ready[g]),
        .rdata   (slot_rdata[32*g +: 32]),
        .hit     (lane_hit[g]),
        .rdata_q (lane_rdata[g])
      );
    end
  endgenerate

  always_comb begin
    dev_ready = 1'b0;
    dev_rdata = 32'h0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      dev_ready = dev_ready | lane_hit[i];
      dev_rdata = dev_rdata | lane_rdata[i];
    end
  end

  // ---------------- optional WAIT timeout ----------------
  logic timeout_fire;
`ifdef MMIO_DECODER_TIMEOUT_EN
  logic [15:0] wait_cnt;
  // Fires in the TIMEOUT_CYCLES-th WAIT cycle; a ready in that cycle wins.
  assign timeout_fire = (state == S_WAIT) && !dev_ready &&
                        ((wait_cnt + 16'd1) == 16'(TIMEOUT_CYCLES));
`else
  logic [15:0] unused_timeout;
  assign unused_timeout = 16'(TIMEOUT_CYCLES);
  assign timeout_fire   = 1'b0;
`endif

  // ---------------- error counter ----------------
  logic err_inc, err_clr;
  assign err_inc = (idle_accept && !is_dev && !ctrl_hit) || timeout_fire;
  assign err_clr = ctrl_wr && (offset == R_STATUS);

  always_ff @(posedge clk) begin
    if (rst) begin
      err_count <= 16'h0;
    end else if (err_clr) begin
      err_count <= 16'h0;                  // clear beats a same-cycle increment
    end else if (err_inc && err_count != 16'hFFFF) begin
      err_count <= err_count + 16'd1;      // saturating
    end
  end

  // ---------------- main FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= S_IDLE;
      act_base        <= DEFAULT_BASE;
      act_bound       <= DEFAULT_BOUND;
      stg_base        <= DEFAULT_BASE;
      stg_bound       <= DEFAULT_BOUND;
      cfg_error       <= 1'b0;
      data_fetch      <= 32'h0;
      data_ready      <= 1'b0;
      bus_error       <= 1'b0;
      slot_sel        <= '0;
      mmio_addr       <= 32'h0;
      mmio_wdata      <= 32'h0;
      mmio_read       <= 1'b0;
      cache_access_ff <= 1'b1;
`ifdef MMIO_DECODER_TIMEOUT_EN
      wait_cnt        <= 16'h0;
`endif
    end else begin
      cache_access_ff <= cache_access;
      data_ready      <= 1'b0;
      bus_error       <= 1'b0;
      case (state)
        S_IDLE: begin
          if (idle_accept) begin
            if (is_dev) begin
              state      <= S_WAIT;
              slot_sel   <= NUM_SLOTS'(1) << slot_idx;
              mmio_addr  <= {{IDX_W{1'b0}}, offset[SB_W-1:0]};
              mmio_wdata <= data_store;
              mmio_read  <= data_read;
`ifdef MMIO_DECODER_TIMEOUT_EN
              wait_cnt   <= 16'h0;
`endif
            end else if (ctrl_hit) begin
              state      <= S_RESP;
              data_ready <= 1'b1;
              data_fetch <= data_read ? ctrl_rdata : 32'h0;
              if (!data_read) begin
                case (offset)
                  R_STG_BASE:  stg_base  <= data_store;
                  R_STG_BOUND: stg_bound <= data_store;
                  R_COMMIT: begin
                    if (commit_ok) begin
                      act_base  <= stg_base;
                      act_bound <= stg_bound;
                    end else begin
                      cfg_error <= 1'b1;
                    end
                  end
                  R_STATUS:    cfg_error <= 1'b0;
                  default: ;   // active-pair readbacks are read-only
                endcase
              end
            end else begin
              // Unmapped: hole in slot 0 or slot index past NUM_SLOTS.
              state      <= S_RESP;
              data_ready <= 1'b1;
              bus_error  <= 1'b1;
              data_fetch <= 32'h0;
            end
          end
        end
        S_WAIT: begin
          // data_enable is not looked at here: the access cannot be aborted.
          if (dev_ready) begin
            state      <= S_RESP;
            data_ready <= 1'b1;
            data_fetch <= mmio_read ? dev_rdata : 32'h0;
            slot_sel   <= '0;
          end else if (timeout_fire) begin
            state      <= S_RESP;
            data_ready <= 1'b1;
            bus_error  <= 1'b1;
            data_fetch <= 32'hDEAD_BEEF;
            slot_sel   <= '0;
          end
`ifdef MMIO_DECODER_TIMEOUT_EN
          else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
`endif
        end
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_decoder_v2.sv
module tb_mmio_decoder_v2;
  localparam int          NS  = 8;
  localparam int          SB  = 1024;
  localparam logic [31:0] DB  = 32'h0020_0000;
  localparam logic [31:0] DBD = 32'h0040_0000;

  logic              clk = 1'b0;
  logic              rst;
  logic [31:0]       data_address, data_store, data_fetch;
  logic              data_read, data_enable, data_ready, bus_error;
  logic              cache_access, cache_access_ff;
  logic [NS-1:0]     slot_sel, slot_ready;
  logic [31:0]       mmio_addr, mmio_wdata;
  logic              mmio_read;
  logic [32*NS-1:0]  slot_rdata;

  mmio_decoder_v2 #(.NUM_SLOTS(NS), .SLOT_BYTES(SB), .DEFAULT_BASE(DB),
                    .DEFAULT_BOUND(DBD), .TIMEOUT_CYCLES(15)) dut (
    .clk(clk), .rst(rst),
    .data_address(data_address), .data_store(data_store),
    .data_read(data_read), .data_enable(data_enable),
    .data_fetch(data_fetch), .data_ready(data_ready), .bus_error(bus_error),
    .cache_access(cache_access), .cache_access_ff(cache_access_ff),
    .slot_sel(slot_sel), .mmio_addr(mmio_addr), .mmio_wdata(mmio_wdata),
    .mmio_read(mmio_read), .slot_ready(slot_ready), .slot_rdata(slot_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] fetch;
    logic        err;
    int          at;
  } exp_t;
  exp_t q[$];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model: the decoder's architectural state.
  logic [31:0] act_b, act_bd, stg_b, stg_bd;
  logic        cerr;
  int          ecnt;

  function automatic void model_reset();
    act_b = DB; act_bd = DBD; stg_b = DB; stg_bd = DBD; cerr = 1'b0; ecnt = 0;
  endfunction

  // Monitor: every completion pops one expectation.
  always @(negedge clk) begin
    if (rst === 1'b0 && data_ready === 1'b1) begin
      if (q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_ready: got data_ready=1 expected none (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("data_fetch", data_fetch, e.fetch);
        chk("bus_error", 32'(bus_error), 32'(e.err));
        chk("ready_cycle", 32'(cyc), 32'(e.at));
      end
    end
  end

  task automatic wait_ready();
    int w = 0;
    while (data_ready !== 1'b1 && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (data_ready !== 1'b1) begin
      n_cmp++; n_bad++;
      $display("FAIL ready_timeout: got no data_ready expected one within 100 cycles");
    end
  endtask

  // One core access; lat = cycles between slot_sel rising and slot_ready.
  task automatic access(input logic [31:0] addr, input logic [31:0] wdata,
                        input logic rd, input int lat, input logic [31:0] rdata,
                        input bit drop);
    logic [31:0] off, idx, f;
    exp_t e;
    int   c;
    bit   unm;
    @(posedge clk); #1;
    data_address = addr; data_store = wdata; data_read = rd; data_enable = 1'b1;
    c = cyc;
    if (!(addr >= act_b && addr < act_bd)) begin
      @(negedge clk);
      chk("cache_access_miss", 32'(cache_access), 32'd1);
      @(posedge clk); #1;
      data_enable = 1'b0;
      @(negedge clk);
      chk("cache_access_ff_miss", 32'(cache_access_ff), 32'd1);
      chk("slot_sel_miss", 32'(slot_sel), 32'd0);
      return;
    end
    off = addr - act_b;
    idx = off / SB;
    @(negedge clk);
    chk("cache_access_hit", 32'(cache_access), 32'd0);
    if (idx != 0 && idx < NS) begin
      e.fetch = rd ? rdata : 32'h0; e.err = 1'b0; e.at = c + 2 + lat;
      q.push_back(e);
      @(negedge clk);
      chk("slot_sel", 32'(slot_sel), 32'd1 << idx);
      chk("mmio_addr", mmio_addr, off % SB);
      chk("mmio_wdata", mmio_wdata, wdata);
      chk("mmio_read", 32'(mmio_read), 32'(rd));
      chk("cache_access_ff_hit", 32'(cache_access_ff), 32'd0);
      if (drop) data_enable = 1'b0;
      // Unselected devices chatter; only the selected one may complete.
      slot_ready = NS'($urandom) & ~(NS'(1) << idx);
      for (int k = 0; k < NS; k++) slot_rdata[32*k +: 32] = $urandom;
      for (int k = 0; k < lat; k++) begin
        @(negedge clk);
        chk("slot_sel_hold", 32'(slot_sel), 32'd1 << idx);
      end
      slot_ready[idx] = 1'b1;
      slot_rdata[32*idx +: 32] = rdata;
    end else begin
      f = 32'h0; unm = (idx != 0);
      if (!unm) begin
        case (off)
          32'h00: if (rd) f = stg_b;  else stg_b  = wdata;
          32'h04: if (rd) f = stg_bd; else stg_bd = wdata;
          32'h08: if (rd) f = act_b;
          32'h0C: if (rd) f = act_bd;
          32'h10: if (!rd) begin
                    if (stg_bd > stg_b && (stg_bd - stg_b) >= NS * SB) begin
                      act_b = stg_b; act_bd = stg_bd;
                    end else cerr = 1'b1;
                  end
          32'h14: if (rd) f = {16'(ecnt), 15'h0, cerr};
                  else begin ecnt = 0; cerr = 1'b0; end
          default: unm = 1'b1;
        endcase
      end
      if (unm) ecnt = (ecnt < 65535) ? ecnt + 1 : 65535;
      e.fetch = f; e.err = unm; e.at = c + 1;
      q.push_back(e);
    end
    wait_ready();
    @(posedge clk); #1;
    data_enable = 1'b0;
    slot_ready  = '0;
  endtask

  function automatic logic [31:0] rand_base();
    return 32'h0010_0000 + (32'($urandom_range(0, 255)) << 12);
  endfunction

  function automatic logic [31:0] rand_bound(input logic [31:0] b);
    case ($urandom_range(0, 4))
      0: return b + NS * SB;          // exactly the minimum span
      1: return b + NS * SB - 4;      // one word short
      2: return b + 32'h0001_0000;
      3: return b - 32'h0000_1000;    // inverted window
      default: return b + 32'h0004_0000;
    endcase
  endfunction

  initial begin
    logic [31:0] a, wd, span;
    int c;
    rst = 1'b1; data_enable = 1'b0; data_address = 0; data_store = 0;
    data_read = 1'b0; slot_ready = '0; slot_rdata = '0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_data_fetch", data_fetch, 32'd0);
    chk("rst_data_ready", 32'(data_ready), 32'd0);
    chk("rst_bus_error", 32'(bus_error), 32'd0);
    chk("rst_slot_sel", 32'(slot_sel), 32'd0);
    chk("rst_mmio_addr", mmio_addr, 32'd0);
    chk("rst_mmio_wdata", mmio_wdata, 32'd0);
    chk("rst_mmio_read", 32'(mmio_read), 32'd0);
    chk("rst_cache_access_ff", 32'(cache_access_ff), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;

    // Directed: default readback, slot 2 device read, re-base, failed commit.
    access(DB + 32'h08, 0, 1'b1, 0, 0, 0);
    access(DB + 32'h0C, 0, 1'b1, 0, 0, 0);
    access(32'h0020_0800, 0, 1'b1, 3, 32'hCAFE_0002, 0);
    access(DB + 32'h00, 32'h0010_0000, 1'b0, 0, 0, 0);
    access(DB + 32'h04, 32'h0020_0000, 1'b0, 0, 0, 0);
    access(DB + 32'h10, 32'h0, 1'b0, 0, 0, 0);
    access(32'h0010_0008, 0, 1'b1, 0, 0, 0);
    access(32'h0030_0000, 0, 1'b1, 0, 0, 0);
    access(32'h0010_0004, 32'h0010_1000, 1'b0, 0, 0, 0);
    access(32'h0010_0010, 32'h1, 1'b0, 0, 0, 0);
    access(32'h0010_000C, 0, 1'b1, 0, 0, 0);
    access(32'h0010_0014, 0, 1'b1, 0, 0, 0);
    access(32'h0010_0014, 32'h0, 1'b0, 0, 0, 0);
    access(32'h0010_0014, 0, 1'b1, 0, 0, 0);
    // Exactly-minimum window, then boundaries and unmapped holes.
    access(32'h0010_0004, 32'h0010_0000 + NS * SB, 1'b0, 0, 0, 0);
    access(32'h0010_0010, 32'h0, 1'b0, 0, 0, 0);
    access(32'h0010_0000 + NS * SB - 1, 32'h55, 1'b0, 0, 0, 0);
    access(32'h0010_0000 + NS * SB, 0, 1'b1, 0, 0, 0);
    access(32'h000F_FFFF, 0, 1'b1, 0, 0, 0);
    access(32'h0010_0018, 0, 1'b1, 0, 0, 0);
    access(32'h0010_0002, 0, 1'b1, 0, 0, 0);
    access(32'h0010_0000, DB, 1'b0, 0, 0, 0);
    access(32'h0010_0004, DBD, 1'b0, 0, 0, 0);
    access(32'h0010_0010, 32'h0, 1'b0, 0, 0, 0);
    access(DB + 32'h2000, 0, 1'b1, 0, 0, 0);
    access(DB + 32'h14, 0, 1'b1, 0, 0, 0);
    access(DB + 32'h1404, 32'h1234_5678, 1'b0, 0, 32'hFFFF_FFFF, 1);

    // Randomized traffic.
    for (int n = 0; n < 300; n++) begin
      int cat;
      cat = $urandom_range(0, 9);
      if (cat < 4) begin
        int si;
        si = $urandom_range(1, NS - 1);
        a  = act_b + 32'(si * SB) + 32'($urandom_range(0, SB - 1));
        access(a, $urandom, 1'($urandom), $urandom_range(0, 5), $urandom, 1'($urandom));
      end else if (cat < 7) begin
        logic [31:0] offs [7];
        int p;
        logic r;
        offs = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h14,
                 32'($urandom_range(32'h15, SB - 1))};
        p = $urandom_range(0, 6);
        r = 1'($urandom);
        if (offs[p] == 32'h00) wd = rand_base();
        else if (offs[p] == 32'h04) wd = rand_bound(stg_b);
        else wd = $urandom;
        access(act_b + offs[p], wd, r, 0, 0, 0);
      end else if (cat < 8) begin
        span = act_bd - act_b;
        if (span > NS * SB)
          a = act_b + NS * SB +
              32'($urandom_range(0, (span - NS * SB - 1) > 32'hFFFF ? 32'hFFFF
                                                                     : span - NS * SB - 1));
        else
          a = act_b + 32'h18 + 32'($urandom_range(0, SB - 32'h19));
        access(a, $urandom, 1'($urandom), 0, 0, 0);
      end else begin
        if ($urandom_range(0, 1) == 1) a = act_b - 1 - 32'($urandom_range(0, 255));
        else a = act_bd + 32'($urandom_range(0, 255));
        access(a, $urandom, 1'($urandom), 0, 0, 0);
      end
    end

`ifdef MMIO_DECODER_TIMEOUT_EN
    begin
      exp_t e;
      @(posedge clk); #1;
      data_address = act_b + 3 * SB; data_read = 1'b1; data_enable = 1'b1;
      slot_ready = '0;
      c = cyc;
      e.fetch = 32'hDEAD_BEEF; e.err = 1'b1; e.at = c + 16;
      q.push_back(e);
      ecnt = (ecnt < 65535) ? ecnt + 1 : 65535;
      wait_ready();
      @(posedge clk); #1;
      data_enable = 1'b0;
      access(act_b + 32'h14, 0, 1'b1, 0, 0, 0);
    end
`endif

    // Reset in the middle of WAIT.
    @(posedge clk); #1;
    data_address = act_b + 3 * SB; data_read = 1'b1; data_enable = 1'b1;
    slot_ready = '0;
    @(negedge clk);
    @(negedge clk);
    chk("wait_slot_sel", 32'(slot_sel), 32'd8);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_wait_slot_sel", 32'(slot_sel), 32'd0);
    chk("rst_wait_ready", 32'(data_ready), 32'd0);
    data_enable = 1'b0;
    rst = 1'b0;
    model_reset();
    access(DB + 32'h08, 0, 1'b1, 0, 0, 0);
    access(DB + 32'h14, 0, 1'b1, 0, 0, 0);

    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
